// File: rtl/core_alu_unit.sv
// core_alu_unit: single-cycle integer ALU for RV32I-style ops.
// One-hot op strobes select the operation; the result is registered so it
// appears exactly one clock after the strobes and operands are presented.
// Conflicting strobes resolve to the op listed first in the port list.
module core_alu_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    // Register-immediate ops
    input  logic            i_addi,
    input  logic            i_slti,
    input  logic            i_sltiu,
    input  logic            i_xori,
    input  logic            i_ori,
    input  logic            i_andi,
    input  logic            i_slli,
    input  logic            i_srli,
    input  logic            i_srai,
    // Register-register ops
    input  logic            i_add,
    input  logic            i_sub,
    input  logic            i_sll,
    input  logic            i_slt,
    input  logic            i_sltu,
    input  logic            i_xor,
    input  logic            i_srl,
    input  logic            i_sra,
    input  logic            i_or,
    input  logic            i_and,
    // Branch compares and load/store address generation
    input  logic            i_beq,
    input  logic            i_bne,
    input  logic            i_blt,
    input  logic            i_bge,
    input  logic            i_bltu,
    input  logic            i_bgeu,
    input  logic            i_lb,
    input  logic            i_lh,
    input  logic            i_lw,
    input  logic            i_lbu,
    input  logic            i_lhu,
    input  logic            i_sb,
    input  logic            i_sh,
    input  logic            i_sw,
    // Operands
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] result
);

    localparam int SHW = $clog2(XLEN);

    // Shift amounts come from the low operand bits only.
    logic [SHW-1:0] shamt_imm;
    logic [SHW-1:0] shamt_rs2;
    assign shamt_imm = imm[SHW-1:0];
    assign shamt_rs2 = rs2[SHW-1:0];

    // Shared adders and comparators; every op below picks from these.
    logic [XLEN-1:0] sum_imm;
    logic [XLEN-1:0] sum_rs2;
    logic [XLEN-1:0] diff_rs2;
    logic            lt_imm_s;
    logic            lt_imm_u;
    logic            lt_rs2_s;
    logic            lt_rs2_u;
    logic            eq_rs2;

    assign sum_imm  = rs1 + imm;
    assign sum_rs2  = rs1 + rs2;
    assign diff_rs2 = rs1 - rs2;
    assign lt_imm_s = $signed(rs1) < $signed(imm);
    assign lt_imm_u = rs1 < imm;
    assign lt_rs2_s = $signed(rs1) < $signed(rs2);
    assign lt_rs2_u = rs1 < rs2;
    assign eq_rs2   = rs1 == rs2;

    // Zero-extend a single flag to a full-width result.
    function automatic logic [XLEN-1:0] flag(input logic f);
        return {{(XLEN-1){1'b0}}, f};
    endfunction

    logic [XLEN-1:0] next_result;

    // Priority-ordered op select: earlier strobes in the port list win.
    always_comb begin
        // NOTE: default first so every path assigns next_result; otherwise a latch is inferred.
        next_result = '0;
        if      (i_addi)  next_result = sum_imm;
        else if (i_slti)  next_result = flag(lt_imm_s);
        else if (i_sltiu) next_result = flag(lt_imm_u);
        else if (i_xori)  next_result = rs1 ^ imm;
        else if (i_ori)   next_result = rs1 | imm;
        else if (i_andi)  next_result = rs1 & imm;
        else if (i_slli)  next_result = rs1 << shamt_imm;
        else if (i_srli)  next_result = rs1 >> shamt_imm;
        else if (i_srai)  next_result = XLEN'($signed(rs1) >>> shamt_imm);
        else if (i_add)   next_result = sum_rs2;
        else if (i_sub)   next_result = diff_rs2;
        else if (i_sll)   next_result = rs1 << shamt_rs2;
        else if (i_slt)   next_result = flag(lt_rs2_s);
        else if (i_sltu)  next_result = flag(lt_rs2_u);
        else if (i_xor)   next_result = rs1 ^ rs2;
        else if (i_srl)   next_result = rs1 >> shamt_rs2;
        else if (i_sra)   next_result = XLEN'($signed(rs1) >>> shamt_rs2);
        else if (i_or)    next_result = rs1 | rs2;
        else if (i_and)   next_result = rs1 & rs2;
        else if (i_beq)   next_result = flag(eq_rs2);
        else if (i_bne)   next_result = flag(!eq_rs2);
        else if (i_blt)   next_result = flag(lt_rs2_s);
        else if (i_bge)   next_result = flag(!lt_rs2_s);
        else if (i_bltu)  next_result = flag(lt_rs2_u);
        else if (i_bgeu)  next_result = flag(!lt_rs2_u);
        else if (i_lb || i_lh || i_lw || i_lbu || i_lhu || i_sb || i_sh || i_sw)
            next_result = sum_imm;
    end

    // Result register: cleared by reset, otherwise reloaded every cycle.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment for state so all flops update together at the edge.
        if (rst) result <= '0;
        else     result <= next_result;
    end

endmodule

// File: tb/tb_core_alu_unit.sv
// tb_core_alu_unit: directed vectors with hand-computed expectations.
// The driver pushes each expected result into a queue as it applies a
// vector; a separate monitor pops one entry per cycle after the edge.
module tb_core_alu_unit;

    // Strobe indices in port order.
    localparam int ADDI = 0,  SLTI = 1,  SLTIU = 2,  XORI = 3,  ORI = 4,  ANDI = 5;
    localparam int SLLI = 6,  SRLI = 7,  SRAI = 8,   ADD = 9,   SUB = 10, SLL = 11;
    localparam int SLT = 12,  SLTU = 13, XOR = 14,   SRL = 15,  SRA = 16, OR = 17;
    localparam int AND = 18,  BEQ = 19,  BNE = 20,   BLT = 21,  BGE = 22, BLTU = 23;
    localparam int BGEU = 24, LB = 25,   LH = 26,    LW = 27,   LBU = 28, LHU = 29;
    localparam int SB = 30,   SH = 31,   SW = 32,    NONE = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic [32:0] st;
    logic [31:0] rs1, rs2, imm;
    logic [31:0] result;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   drive_done = 1'b0;

    always #5 clk = ~clk;

    core_alu_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .i_addi(st[ADDI]), .i_slti(st[SLTI]), .i_sltiu(st[SLTIU]), .i_xori(st[XORI]),
        .i_ori(st[ORI]), .i_andi(st[ANDI]), .i_slli(st[SLLI]), .i_srli(st[SRLI]),
        .i_srai(st[SRAI]),
        .i_add(st[ADD]), .i_sub(st[SUB]), .i_sll(st[SLL]), .i_slt(st[SLT]),
        .i_sltu(st[SLTU]), .i_xor(st[XOR]), .i_srl(st[SRL]), .i_sra(st[SRA]),
        .i_or(st[OR]), .i_and(st[AND]),
        .i_beq(st[BEQ]), .i_bne(st[BNE]), .i_blt(st[BLT]), .i_bge(st[BGE]),
        .i_bltu(st[BLTU]), .i_bgeu(st[BGEU]), .i_lb(st[LB]), .i_lh(st[LH]),
        .i_lw(st[LW]), .i_lbu(st[LBU]), .i_lhu(st[LHU]), .i_sb(st[SB]),
        .i_sh(st[SH]), .i_sw(st[SW]),
        .rs1(rs1), .rs2(rs2), .imm(imm), .result(result)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] one(input int idx);
        logic [33:0] v;
        v = 34'd1 << idx;
        return v[32:0];
    endfunction

    // Apply one vector away from the active edge and queue its expectation.
    task automatic apply(input string name, input logic [32:0] strobes, input logic r,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] i,
                         input logic [31:0] exp);
        exp_t e;
        @(negedge clk);
        rst = r;
        st  = strobes;
        rs1 = a;
        rs2 = b;
        imm = i;
        e.exp  = exp;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: the result is valid every cycle, so pop once per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, result, e.exp);
            end
        end
    end

    // Driver
    initial begin
        rst = 1'b1; st = '0; rs1 = '0; rs2 = '0; imm = '0;

        apply("reset_addi",   one(ADDI), 1'b1, 32'h000000F0, 32'h0, 32'h0000000F, 32'h0);
        apply("reset_add",    one(ADD),  1'b1, 32'h12345678, 32'h11111111, 32'h0, 32'h0);

        apply("addi",         one(ADDI),  1'b0, 32'h000000F0, 32'h0, 32'h0000000F, 32'h000000FF);
        apply("addi_wrap",    one(ADDI),  1'b0, 32'hFFFFFFFF, 32'h0, 32'h00000001, 32'h0);
        apply("slti",         one(SLTI),  1'b0, 32'h86C160F0, 32'h0, 32'h70F0680F, 32'h1);
        apply("sltiu",        one(SLTIU), 1'b0, 32'h86C160F0, 32'h0, 32'h70F0680F, 32'h0);
        apply("slt",          one(SLT),   1'b0, 32'h86C160F0, 32'h70F0680F, 32'h0, 32'h1);
        apply("sltu",         one(SLTU),  1'b0, 32'h86C160F0, 32'h70F0680F, 32'h0, 32'h0);
        apply("srai",         one(SRAI),  1'b0, 32'h8E5460F5, 32'h1, 32'h4, 32'hF8E5460F);
        apply("srli",         one(SRLI),  1'b0, 32'h8E5460F5, 32'h1, 32'h4, 32'h08E5460F);
        apply("slli",         one(SLLI),  1'b0, 32'h0E5460F5, 32'h1, 32'h4, 32'hE5460F50);
        apply("srai_zero",    one(SRAI),  1'b0, 32'h8E5460F5, 32'h1, 32'h00000020, 32'h8E5460F5);
        apply("sub",          one(SUB),   1'b0, 32'h09439AD4, 32'h00531794, 32'h0, 32'h08F08340);
        apply("add",          one(ADD),   1'b0, 32'h09439AD4, 32'h00531794, 32'h0, 32'h0996B268);
        apply("xori",         one(XORI),  1'b0, 32'hFF00FF00, 32'h0, 32'h0F0F0F0F, 32'hF00FF00F);
        apply("ori",          one(ORI),   1'b0, 32'hFF00FF00, 32'h0, 32'h0F0F0F0F, 32'hFF0FFF0F);
        apply("andi",         one(ANDI),  1'b0, 32'hFF00FF00, 32'h0, 32'h0F0F0F0F, 32'h0F000F00);
        apply("and",          one(AND),   1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0, 32'h0F000F00);
        apply("or",           one(OR),    1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0, 32'hFF0FFF0F);
        apply("xor",          one(XOR),   1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0, 32'hF00FF00F);
        apply("sra_upper",    one(SRA),   1'b0, 32'h80000000, 32'h00000023, 32'h0, 32'hF0000000);
        apply("srl_upper",    one(SRL),   1'b0, 32'h80000000, 32'h00000023, 32'h0, 32'h10000000);
        apply("sll_31",       one(SLL),   1'b0, 32'h00000001, 32'h0000003F, 32'h0, 32'h80000000);
        apply("sw",           one(SW),    1'b0, 32'h00000003, 32'h0, 32'h00000004, 32'h7);
        apply("lw_neg",       one(LW),    1'b0, 32'h00000010, 32'h0, 32'hFFFFFFFC, 32'h0000000C);
        apply("sb_wrap",      one(SB),    1'b0, 32'hFFFFFFFF, 32'h0, 32'h00000001, 32'h0);
        apply("lhu",          one(LHU),   1'b0, 32'h00001000, 32'h0, 32'h00000022, 32'h00001022);
        apply("beq",          one(BEQ),   1'b0, 32'h5, 32'h5, 32'h0, 32'h1);
        apply("bne",          one(BNE),   1'b0, 32'h5, 32'h5, 32'h0, 32'h0);
        apply("bltu",         one(BLTU),  1'b0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);
        apply("blt",          one(BLT),   1'b0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h1);
        apply("bge",          one(BGE),   1'b0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);
        apply("bgeu",         one(BGEU),  1'b0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h1);
        apply("no_strobe",    '0,         1'b0, 32'hDEADBEEF, 32'h12345678, 32'h1, 32'h0);
        apply("prio_addi_sub", one(ADDI) | one(SUB), 1'b0,
              32'h000000F0, 32'h00000001, 32'h0000000F, 32'h000000FF);
        apply("prio_add_sub", one(ADD) | one(SUB), 1'b0,
              32'h00000010, 32'h00000001, 32'h0, 32'h00000011);
        apply("prio_and_beq", one(AND) | one(BEQ) | one(SW), 1'b0,
              32'h000000F3, 32'h000000F3, 32'h0, 32'h000000F3);
        apply("pre_reset",    one(ADD),   1'b0, 32'h00000002, 32'h00000003, 32'h0, 32'h5);
        apply("mid_reset",    one(ADD),   1'b1, 32'h00000004, 32'h00000005, 32'h0, 32'h0);
        apply("post_reset",   one(SUB),   1'b0, 32'h00000009, 32'h00000004, 32'h0, 32'h5);

        // Drain: every queued expectation must be consumed within two edges.
        @(negedge clk);
        st = '0;
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        drive_done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        if (!drive_done) begin
            $display("FAIL watchdog: driver did not finish, required completion");
            $fatal(1, "watchdog expired");
        end
    end

endmodule

// File: doc/core_alu_unit.md
CORE_ALU_UNIT -- requirements
Module: core_alu

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data width; all width rules below use XLEN=32.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, a synchronous active-high reset sampled on the rising edge of clk.
REQ-004 The block SHALL have one-hot op strobe inputs, each 1 bit wide: i_addi, i_slti, i_sltiu, i_xori, i_ori, i_andi, i_slli, i_srli, i_srai.
REQ-005 The block SHALL have one-hot op strobe inputs, each 1 bit wide: i_add, i_sub, i_sll, i_slt, i_sltu, i_xor, i_srl, i_sra, i_or, i_and.
REQ-006 The block SHALL have one-hot op strobe inputs, each 1 bit wide: i_beq, i_bne, i_blt, i_bge, i_bltu, i_bgeu, i_lb, i_lh, i_lw, i_lbu, i_lhu, i_sb, i_sh, i_sw.
REQ-007 The block SHALL have port rs1, input, 32, source operand 1.
REQ-008 The block SHALL have port rs2, input, 32, source operand 2.
REQ-009 The block SHALL have port imm, input, 32, immediate, already sign-extended by the decoder.
REQ-010 The block SHALL have port result, output, 32, the registered ALU result.
REQ-011 Port order SHALL be: clk, rst, the strobes in the order of REQ-004..006, rs1, rs2, imm, result.

Function
REQ-012 result SHALL be a register updated every rising clk edge when rst=0; latency from inputs to result is exactly 1 cycle.
REQ-013 The block SHALL compute ADDI = rs1+imm, SUB = rs1-rs2 and ADD = rs1+rs2, all modulo 2^32 with overflow ignored.
REQ-014 The block SHALL compute XORI/ORI/ANDI bitwise on rs1 and imm, and XOR/OR/AND bitwise on rs1 and rs2.
REQ-015 The block SHALL compute SLTI/SLT = 1 if rs1 < operand under signed two's-complement compare, else 0; operand is imm or rs2 respectively; bits [31:1] are 0.
REQ-016 The block SHALL compute SLTIU/SLTU with the same rule as REQ-015 but an unsigned compare.
REQ-017 The block SHALL compute SLLI/SRLI/SRAI with shift amount imm[4:0] and SLL/SRL/SRA with shift amount rs2[4:0]; upper operand bits are ignored.
REQ-018 Logical shifts SHALL zero-fill, and SRA/SRAI SHALL replicate rs1[31]; a shift amount of 0 SHALL return rs1 unchanged.
REQ-019 For branches, result SHALL be 32'd1 if the condition holds, else 0: BEQ rs1==rs2, BNE rs1!=rs2, BLT/BGE signed <,>=, BLTU/BGEU unsigned <,>=.
REQ-020 For loads and stores (LB, LH, LW, LBU, LHU, SB, SH, SW), result SHALL be the effective address rs1+imm modulo 2^32.
REQ-021 If no strobe is asserted, the next result SHALL be 0.
REQ-022 If several strobes are asserted, the lowest-numbered op in port order SHALL win, for deterministic behaviour.
REQ-023 Strobes and operands SHALL be sampled on the same edge, and result SHALL track new inputs every cycle with no handshake and no stall.

Reset
REQ-024 When rst=1 at a rising clk edge, result SHALL become 0 regardless of strobes or operands.
REQ-025 Reset mid-operation SHALL discard the pending result, and the first edge after rst deasserts SHALL produce a normal result from the inputs present then.
REQ-026 There SHALL be no other state.

Verification
REQ-027 ADDI with rs1=0x000000F0, imm=0x0000000F -> result=0x000000FF one cycle later.
REQ-028 SLTI with rs1=0x86C160F0, imm=0x70F0680F -> result 1; SLTIU with the same operands -> result 0; SLT/SLTU with imm replaced by rs2 -> results 1/0.
REQ-029 SRAI with rs1=0x8E5460F5, imm=4 (rs2=1 ignored) -> 0xF8E5460F; SRLI with the same operands -> 0x08E5460F; SLLI with rs1=0x0E5460F5 -> 0xE5460F50.
REQ-030 SUB with rs1=0x09439AD4, rs2=0x00531794 -> 0x08F08340; ADD with the same operands -> 0x0996B268.
REQ-031 SW with rs1=3, imm=4 -> 7; BEQ with rs1=rs2=5 -> 1; BLTU with rs1=0xFFFFFFFF, rs2=0 -> 0.
REQ-032 Any op with rst=1 held -> result 0; no strobe asserted -> result 0 on the next edge.
